axi_dma_rd_sched: RTL and testbench

// - Shares one axi_dma_rd read engine (descriptor in, status out, AXIS data out) between NUM_REQ requesters.
// - Round-robin arbitration at descriptor granularity; one descriptor in flight at a time (engine tag fixed to 0).
// - Routes the engine's AXIS read stream and completion back to the granted requester.
// - Sits between client blocks and the DMA read wrapper; shares clk/rst with it.

---
 rtl/axi_dma_rd_sched.sv | 105 ++++++++++
 tb/tb_axi_dma_rd_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dma_rd_sched.sv
// axi_dma_rd_sched: round-robin sharing of one DMA read engine among NUM_REQ requesters.
// Define AXI_DMA_RD_SCHED_STATS_EN to add per-requester completion counters on stat_cnt.
module axi_dma_rd_sched #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH      = 9,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]      req_len,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                req_done,
  output logic [DATA_WIDTH-1:0]             rd_tdata,
  output logic                              rd_tlast,
  output logic [NUM_REQ-1:0]                rd_tvalid,
  input  logic [NUM_REQ-1:0]                rd_tready,
  output logic [AXI_ADDR_WIDTH-1:0]         dma_desc_addr,
  output logic [LEN_WIDTH-1:0]              dma_desc_len,
  output logic                              dma_desc_valid,
  input  logic                              dma_desc_ready,
  input  logic                              dma_status_valid,
  input  logic [DATA_WIDTH-1:0]             dma_tdata,
  input  logic                              dma_tvalid,
  input  logic                              dma_tlast,
  output logic                              dma_tready
`ifdef AXI_DMA_RD_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]             stat_cnt
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;
  state_t                    state;
  logic [PW-1:0]             rr_ptr, grant, win;
  logic [NUM_REQ-1:0]        done;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic                      last_seen, stat_seen, xfer, accept, last_all, stat_all;
  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    win = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[PW'((int'(rr_ptr) + i) % NUM_REQ)]) win = PW'((int'(rr_ptr) + i) % NUM_REQ);
  end
  // Arbitration is held off while a completion pulse is still showing.
  assign accept         = (state == IDLE) && !(|done) && (|req_valid) && !rst;
  assign req_ready      = accept ? NUM_REQ'(1) << win : '0;
  assign req_done       = done;
  assign xfer           = (state == XFER);
  assign dma_tready     = xfer & rd_tready[grant];
  assign rd_tvalid      = xfer ? NUM_REQ'(dma_tvalid) << grant : '0;
  assign rd_tdata       = xfer ? dma_tdata : '0;
  assign rd_tlast       = xfer & dma_tlast;
  assign dma_desc_valid = (state == ISSUE);
  assign dma_desc_addr  = addr_q;
  assign dma_desc_len   = len_q;
  assign last_all       = last_seen | (dma_tvalid & dma_tready & dma_tlast);
  assign stat_all       = stat_seen | (xfer & dma_status_valid);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      done      <= '0;
      last_seen <= 1'b0;
      stat_seen <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: if (accept) begin
          grant  <= win;
          addr_q <= req_addr[int'(win)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
          len_q  <= req_len[int'(win)*LEN_WIDTH +: LEN_WIDTH];
          rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          if (req_len[int'(win)*LEN_WIDTH +: LEN_WIDTH] == '0) done <= NUM_REQ'(1) << win;
          else state <= ISSUE;
        end
        ISSUE: if (dma_desc_ready) state <= XFER;
        XFER: if (last_all && stat_all) begin
          done      <= NUM_REQ'(1) << grant;
          last_seen <= 1'b0;
          stat_seen <= 1'b0;
          state     <= IDLE;
        end else begin
          last_seen <= last_all;
          stat_seen <= stat_all;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef AXI_DMA_RD_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_cnt <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (done[i]) stat_cnt[i*16 +: 16] <= stat_cnt[i*16 +: 16] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_axi_dma_rd_sched.sv
// tb_axi_dma_rd_sched: random requesters and engine, scoreboard monitor against a cycle-level reference.
module tb_axi_dma_rd_sched;
  localparam int NR = 4, AW = 32, LW = 9, DW = 32;
  localparam int P_IDLE = 0, P_ISSUE = 1, P_XFER = 2, P_WAIT = 3;
  logic clk, rst;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0] req_valid, req_ready, req_done, rd_tvalid, rd_tready;
  logic [DW-1:0] rd_tdata, dma_tdata;
  logic rd_tlast, dma_desc_valid, dma_desc_ready, dma_status_valid, dma_tvalid, dma_tlast, dma_tready;
  logic [AW-1:0] dma_desc_addr;
  logic [LW-1:0] dma_desc_len;
`ifdef AXI_DMA_RD_SCHED_STATS_EN
  logic [NR*16-1:0] stat_cnt;
`endif
  axi_dma_rd_sched #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_len(req_len), .req_valid(req_valid),
    .req_ready(req_ready), .req_done(req_done), .rd_tdata(rd_tdata), .rd_tlast(rd_tlast),
    .rd_tvalid(rd_tvalid), .rd_tready(rd_tready), .dma_desc_addr(dma_desc_addr),
    .dma_desc_len(dma_desc_len), .dma_desc_valid(dma_desc_valid), .dma_desc_ready(dma_desc_ready),
    .dma_status_valid(dma_status_valid), .dma_tdata(dma_tdata), .dma_tvalid(dma_tvalid),
    .dma_tlast(dma_tlast), .dma_tready(dma_tready)
`ifdef AXI_DMA_RD_SCHED_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int cyc = 0, m_phase = P_IDLE, m_rr = 0, m_grant = 0, done_cyc = -1, arb_ok = 0;
  int t_last = -1, t_stat = -1, ph_t = 0;
  int m_cnt [NR];
  logic [AW-1:0] exp_addr;
  logic [LW-1:0] exp_len;
  logic [DW:0] beat_q [$];
  int load = 0;
  logic burst = 1'b0, tog = 1'b0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " req_ready"}, 64'(req_ready), 0);
    chk({tag, " req_done"}, 64'(req_done), 0);
    chk({tag, " rd_tvalid"}, 64'(rd_tvalid), 0);
    chk({tag, " rd_tdata"}, 64'(rd_tdata), 0);
    chk({tag, " rd_tlast"}, 64'(rd_tlast), 0);
    chk({tag, " dma_desc_valid"}, 64'(dma_desc_valid), 0);
    chk({tag, " dma_desc_addr"}, 64'(dma_desc_addr), 0);
    chk({tag, " dma_tready"}, 64'(dma_tready), 0);
  endtask
  // Requesters: hold a descriptor until accepted, then maybe raise a new one.
  initial begin
    logic [NR-1:0] acc;
    req_valid = '0; req_addr = '0; req_len = '0; rd_tready = '0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      tog = ~tog;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && int'($urandom_range(0, 99)) < load) begin
          req_addr[i*AW +: AW] = $urandom;
          req_len[i*LW +: LW] = burst ? LW'(4) : ($urandom_range(0, 4) == 0 ? '0 : LW'($urandom_range(1, 40)));
          req_valid[i] = 1'b1;
        end
      end
      rd_tready = burst ? {NR{tog}} : NR'($urandom);
    end
  end
  // Engine: accepts a descriptor, streams ceil(len/4) beats and one status pulse.
  task automatic engine_one();
    int n, mode;
    logic hs;
    logic [DW-1:0] dat;
    @(posedge clk); #2;
    {dma_desc_ready, dma_status_valid, dma_tvalid, dma_tlast} = '0;
    if (rst || !dma_desc_valid) return;
    repeat ($urandom_range(0, 2)) begin
      dma_status_valid = 1'($urandom_range(0, 1));
      dma_tvalid = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
      {dma_status_valid, dma_tvalid} = '0;
      if (rst) return;
    end
    dma_desc_ready = 1'b1;
    n = (int'(dma_desc_len) + 3) / 4;
    @(posedge clk); #2;
    dma_desc_ready = 1'b0;
    if (rst) return;
    mode = $urandom_range(0, 2);
    if (mode == 0) begin
      dma_status_valid = 1'b1;
      @(posedge clk); #2;
      dma_status_valid = 1'b0;
      if (rst) return;
    end
    for (int b = 0; b < n; b++) begin
      while ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #2;
        if (rst) return;
      end
      dat = $urandom;
      beat_q.push_back({b == n - 1, dat});
      dma_tvalid = 1'b1; dma_tdata = dat; dma_tlast = (b == n - 1);
      forever begin
        hs = dma_tready;
        dma_status_valid = (mode == 2) && (b == n - 1) && hs;
        @(posedge clk); #2;
        if (rst) return;
        if (hs) break;
      end
      {dma_tvalid, dma_tlast, dma_status_valid} = '0;
    end
    if (mode == 1) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #2;
        if (rst) return;
      end
      dma_status_valid = 1'b1;
      @(posedge clk); #2;
      dma_status_valid = 1'b0;
    end
  endtask
  initial begin
    {dma_desc_ready, dma_status_valid, dma_tvalid, dma_tlast} = '0;
    dma_tdata = '0;
    forever engine_one();
  end
  // Monitor: reference model of grant order, descriptor, routing and completion timing.
  always @(negedge clk) begin
    logic [NR-1:0] exp_ready, exp_done;
    logic [DW:0] b;
    int w, ph;
    cyc++;
    if (rst) begin
      chk_zero("reset");
      m_phase = P_IDLE; m_rr = 0; done_cyc = -1; arb_ok = 0;
      beat_q.delete();
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    end else begin
`ifdef AXI_DMA_RD_SCHED_STATS_EN
      for (int i = 0; i < NR; i++) chk("stat_cnt", 64'(stat_cnt[i*16 +: 16]), 64'(m_cnt[i] & 16'hFFFF));
`endif
      ph = m_phase;
      exp_done = (cyc == done_cyc) ? NR'(1) << m_grant : '0;
      chk("req_done", 64'(req_done), 64'(exp_done));
      if (cyc == done_cyc) begin
        m_phase = P_IDLE; arb_ok = cyc + 1; m_cnt[m_grant]++;
      end
      if (ph == P_ISSUE) begin
        chk("dma_desc_valid", 64'(dma_desc_valid), 1);
        chk("dma_desc_addr", 64'(dma_desc_addr), 64'(exp_addr));
        chk("dma_desc_len", 64'(dma_desc_len), 64'(exp_len));
        if (dma_desc_ready) begin m_phase = P_XFER; t_last = -1; t_stat = -1; end
      end else chk("dma_desc_valid idle", 64'(dma_desc_valid), 0);
      if (ph == P_XFER) begin
        chk("rd_tvalid", 64'(rd_tvalid), 64'(dma_tvalid ? NR'(1) << m_grant : NR'(0)));
        chk("dma_tready", 64'(dma_tready), 64'(rd_tready[m_grant]));
        if (rd_tvalid[m_grant] && rd_tready[m_grant]) begin
          if (beat_q.size() == 0) chk("beat_extra", 1, 0);
          else begin
            b = beat_q.pop_front();
            chk("rd_tdata", 64'(rd_tdata), 64'(b[DW-1:0]));
            chk("rd_tlast", 64'(rd_tlast), 64'(b[DW]));
            if (b[DW]) t_last = cyc;
          end
        end
        if (dma_status_valid && t_stat < 0) t_stat = cyc;
        if (t_last >= 0 && t_stat >= 0) begin
          chk("beats_left", 64'(beat_q.size()), 0);
          done_cyc = (t_last > t_stat ? t_last : t_stat) + 1;
          m_phase = P_WAIT;
        end
      end else begin
        chk("rd_tvalid idle", 64'(rd_tvalid), 0);
        chk("dma_tready idle", 64'(dma_tready), 0);
      end
      w = -1;
      if (m_phase == P_IDLE && cyc >= arb_ok)
        for (int k = 0; k < NR; k++)
          if (w < 0 && req_valid[(m_rr + k) % NR]) w = (m_rr + k) % NR;
      exp_ready = (w >= 0) ? NR'(1) << w : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      if (w >= 0) begin
        m_grant = w; m_rr = (w + 1) % NR; ph_t = cyc;
        exp_addr = req_addr[w*AW +: AW];
        exp_len = req_len[w*LW +: LW];
        if (exp_len == '0) begin done_cyc = cyc + 1; m_phase = P_WAIT; end
        else m_phase = P_ISSUE;
      end
      if (m_phase != P_IDLE && cyc - ph_t > 400) begin
        chk("stuck", 64'(m_phase), P_IDLE);
        m_phase = P_IDLE;
      end
    end
  end
  initial begin
    int i;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    burst = 1'b1; load = 100;
    repeat (300) @(posedge clk);
    burst = 1'b0; load = 30;
    repeat (3000) @(posedge clk);
    for (i = 0; i < 500 && m_phase != P_XFER; i++) @(negedge clk);
    chk("reach_xfer", 64'(m_phase == P_XFER), 1);
    #3 rst = 1'b1;
    #1 chk_zero("async_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (1000) @(posedge clk);
    load = 0;
    for (i = 0; i < 2000 && !(m_phase == P_IDLE && req_valid == '0 && cyc > arb_ok); i++) @(negedge clk);
    chk("drain", 64'(m_phase == P_IDLE && req_valid == '0), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
